// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word-aligned imem requests,
// buffers returned words with their PC and hands them to decode.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INF_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      pc;
  logic [31:0]      tag;
  logic [31:0]      buf_pc    [FIFO_DEPTH];
  logic [31:0]      buf_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             outstanding;
  logic             discard;

  logic             head_valid;
  logic             resp;
  logic             grant;
  logic             push;
  logic             pop;
  logic [INF_W-1:0] inflight;

  // Request is held off while a dropped response is still owed, or when the
  // buffer could not absorb the word already in flight plus a new one.
  always_comb begin
    inflight   = INF_W'(count) + INF_W'(outstanding);
    head_valid = rst_n & (count != '0);
    resp       = imem_rvalid_i & outstanding;
    imem_req_o = rst_n & ~redirect_i & ~discard
               & (~outstanding | imem_rvalid_i)
               & (inflight < INF_W'(FIFO_DEPTH));
    grant      = imem_req_o & imem_gnt_i;
    push       = resp & ~discard & ~redirect_i;
    pop        = head_valid & instr_ready_i & ~redirect_i;
  end

  assign imem_addr_o   = {pc[31:2], 2'b00};
  assign instr_valid_o = head_valid;
  assign instr_o       = head_valid ? buf_instr[rd_ptr] : NOP;
  assign pc_o          = head_valid ? buf_pc[rd_ptr] : '0;

  // Control state; redirect flushes everything and owes one drop if a
  // response is still out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC & ~32'h3;
      tag         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (redirect_i) begin
      pc          <= redirect_pc_i & ~32'h3;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding & ~imem_rvalid_i;
      discard     <= outstanding & ~imem_rvalid_i;
    end else begin
      if (grant) begin
        pc  <= pc + 32'd4;
        tag <= imem_addr_o;
      end
      if (grant) begin
        outstanding <= 1'b1;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp && discard) begin
        discard <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Buffer storage needs no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= tag;
      buf_instr[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table driven against an
// always-grant, next-cycle-response memory, plus reset and PC-wrap sequences.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int unsigned N_VECS = 34;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, gnt, rvalid, redirect, ready;
  logic [31:0] rdata, rpc;
  logic        req, valid;
  logic [31:0] addr, instr, pco;

  logic        w_rst_n, w_rvalid;
  logic [31:0] w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pco;

  int tests = 0;
  int fails = 0;

  logic        pend_valid;
  logic [31:0] pend_addr;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(rpc),
    .instr_valid_o(valid), .instr_ready_i(ready),
    .instr_o(instr), .pc_o(pco)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0000_0000),
    .instr_valid_o(w_valid), .instr_ready_i(1'b1),
    .instr_o(w_instr), .pc_o(w_pco)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        hold;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [N_VECS];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic vec_t mk(input logic r, input logic rdy, input logic hold,
                              input logic redir, input logic [31:0] rp,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.hold = hold; v.redir = redir; v.rpc = rp;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Drive one cycle of inputs #1 after the edge; outputs are sampled at +2.
  task automatic cycle_main(input logic r, input logic rdy, input logic hold,
                            input logic redir, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst_n    = r;
    ready    = rdy;
    redirect = redir;
    rpc      = rp;
    rvalid   = pend_valid & ~hold;
    rdata    = rvalid ? dat(pend_addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic update_pend();
    if (rvalid) pend_valid = 1'b0;
    if (req && gnt) begin
      pend_valid = 1'b1;
      pend_addr  = addr;
    end
  endtask

  task automatic chk_main(input int row, input logic e_req, input logic [31:0] e_addr,
                          input logic e_valid, input logic [31:0] e_pc);
    chk("req",   row, 32'(req),   32'(e_req));
    chk("addr",  row, addr,       e_addr);
    chk("valid", row, 32'(valid), 32'(e_valid));
    chk("pc",    row, pco,        e_valid ? e_pc : 32'h0);
    chk("instr", row, instr,      e_valid ? dat(e_pc) : NOP);
  endtask

  task automatic chk_wrap(input int row, input logic e_req, input logic [31:0] e_addr,
                          input logic e_valid, input logic [31:0] e_pc);
    chk("w_req",   row, 32'(w_req),   32'(e_req));
    chk("w_addr",  row, w_addr,       e_addr);
    chk("w_valid", row, 32'(w_valid), 32'(e_valid));
    chk("w_pc",    row, w_pco,        e_valid ? e_pc : 32'h0);
    chk("w_instr", row, w_instr,      e_valid ? dat(e_pc) : NOP);
  endtask

  initial begin
    //                rst rdy hold rdr rpc            req addr           vld pc
    vecs[0]  = mk(0, 1, 0, 0, 32'h0,       0, 32'h0000_0000, 0, 32'h0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0000, 0, 32'h0);
    vecs[2]  = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0004, 0, 32'h0);
    vecs[3]  = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0008, 1, 32'h0000_0000);
    vecs[4]  = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0008, 1, 32'h0000_0004);
    vecs[5]  = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_000C, 0, 32'h0);
    vecs[6]  = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0010, 1, 32'h0000_0008);
    vecs[7]  = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0010, 1, 32'h0000_000C);
    // decode stalls for six cycles: buffer fills to two, then requests stop
    vecs[8]  = mk(1, 0, 0, 0, 32'h0,       1, 32'h0000_0014, 0, 32'h0);
    vecs[9]  = mk(1, 0, 0, 0, 32'h0,       0, 32'h0000_0018, 1, 32'h0000_0010);
    vecs[10] = mk(1, 0, 0, 0, 32'h0,       0, 32'h0000_0018, 1, 32'h0000_0010);
    vecs[11] = mk(1, 0, 0, 0, 32'h0,       0, 32'h0000_0018, 1, 32'h0000_0010);
    vecs[12] = mk(1, 0, 0, 0, 32'h0,       0, 32'h0000_0018, 1, 32'h0000_0010);
    vecs[13] = mk(1, 0, 0, 0, 32'h0,       0, 32'h0000_0018, 1, 32'h0000_0010);
    vecs[14] = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0018, 1, 32'h0000_0010);
    vecs[15] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0018, 1, 32'h0000_0014);
    vecs[16] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_001C, 0, 32'h0);
    vecs[17] = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0020, 1, 32'h0000_0018);
    vecs[18] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0020, 1, 32'h0000_001C);
    // redirect while the request for 0x20 is out: its response is dropped
    vecs[19] = mk(1, 1, 1, 1, 32'h0000_0103, 0, 32'h0000_0024, 0, 32'h0);
    vecs[20] = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0100, 0, 32'h0);
    vecs[21] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0100, 0, 32'h0);
    vecs[22] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0104, 0, 32'h0);
    // redirect coinciding with rvalid and a pop: nothing survives
    vecs[23] = mk(1, 1, 0, 1, 32'h0000_0200, 0, 32'h0000_0108, 1, 32'h0000_0100);
    vecs[24] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0200, 0, 32'h0);
    vecs[25] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0204, 0, 32'h0);
    vecs[26] = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0208, 1, 32'h0000_0200);
    vecs[27] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0208, 1, 32'h0000_0204);
    // back-to-back redirects: last target wins, one drop owed
    vecs[28] = mk(1, 1, 1, 1, 32'h0000_0300, 0, 32'h0000_020C, 0, 32'h0);
    vecs[29] = mk(1, 1, 1, 1, 32'h0000_0400, 0, 32'h0000_0300, 0, 32'h0);
    vecs[30] = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0400, 0, 32'h0);
    vecs[31] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0400, 0, 32'h0);
    vecs[32] = mk(1, 1, 0, 0, 32'h0,       1, 32'h0000_0404, 0, 32'h0);
    vecs[33] = mk(1, 1, 0, 0, 32'h0,       0, 32'h0000_0408, 1, 32'h0000_0400);

    rst_n = 1'b0; gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; rpc = 32'h0; ready = 1'b1;
    w_rst_n = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    pend_valid = 1'b0; pend_addr = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < int'(N_VECS); i++) begin
      cycle_main(vecs[i].rst, vecs[i].rdy, vecs[i].hold, vecs[i].redir, vecs[i].rpc);
      chk_main(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc);
      update_pend();
    end

    // reset with one entry buffered and a request in flight
    cycle_main(1, 0, 0, 0, 32'h0);
    chk_main(100, 1, 32'h0000_0408, 1, 32'h0000_0404);
    update_pend();
    cycle_main(0, 0, 1, 0, 32'h0);
    chk("rst_req",   101, 32'(req),   32'h0);
    chk("rst_valid", 101, 32'(valid), 32'h0);
    chk("rst_instr", 101, instr,      NOP);
    chk("rst_pc",    101, pco,        32'h0);
    update_pend();
    // the stale response for 0x408 now arrives and must be ignored
    cycle_main(1, 1, 0, 0, 32'h0);
    chk_main(102, 1, 32'h0000_0000, 0, 32'h0);
    update_pend();
    cycle_main(1, 1, 0, 0, 32'h0);
    chk_main(103, 1, 32'h0000_0004, 0, 32'h0);
    update_pend();
    cycle_main(1, 1, 0, 0, 32'h0);
    chk_main(104, 0, 32'h0000_0008, 1, 32'h0000_0000);
    update_pend();

    // PC wrap from a reset value near the top of the address space
    @(posedge clk); #1; #1;
    chk_wrap(200, 0, 32'hFFFF_FFF8, 0, 32'h0);
    @(posedge clk); #1; w_rst_n = 1'b1; w_rvalid = 1'b0; #1;
    chk_wrap(201, 1, 32'hFFFF_FFF8, 0, 32'h0);
    @(posedge clk); #1; w_rvalid = 1'b1; w_rdata = dat(32'hFFFF_FFF8); #1;
    chk_wrap(202, 1, 32'hFFFF_FFFC, 0, 32'h0);
    @(posedge clk); #1; w_rvalid = 1'b1; w_rdata = dat(32'hFFFF_FFFC); #1;
    chk_wrap(203, 0, 32'h0000_0000, 1, 32'hFFFF_FFF8);
    @(posedge clk); #1; w_rvalid = 1'b0; w_rdata = 32'h0; #1;
    chk_wrap(204, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
